mp_alu_sequencer: RTL and testbench

//  Multi-byte arithmetic sequencer driving the 8-bit shift/add ALU.
//  - Accepts one command: ADD, SHL1, SHR1 or SRA1 on a 1..15-byte operand held in data memory.
//  - Walks the operand byte-by-byte and drives ALU op, carry and overflow inputs.
//  - Chains the carry or shifted-out bit between bytes itself, then writes each result byte back.
//  - Sits between the core control unit (command side) and the ALU plus data-memory port.

---
 rtl/mp_alu_sequencer_if.sv | 59 +++++
 rtl/mp_alu_sequencer.sv | 263 ++++++++++++++++++++++++++
 tb/tb_mp_alu_sequencer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/mp_alu_sequencer_if.sv
// mp_alu_sequencer_if: command, data-memory and ALU signals of the multi-byte sequencer.
// The slave modport is the sequencer's view; master is the surrounding control/memory/ALU.
// Optional feature: define MPSEQ_ABORT_EN to add the abort / aborted pair.
interface mp_alu_sequencer_if #(
  parameter int AW    = 8,
  parameter int LEN_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [LEN_W-1:0] cmd_len;
  logic [AW-1:0]    cmd_addr_a;
  logic [AW-1:0]    cmd_addr_b;
  logic [AW-1:0]    cmd_addr_d;
  logic             busy;
  logic             done;
  logic             carry_out;
  logic [AW-1:0]    mem_addr;
  logic [7:0]       mem_rd_data;
  logic             mem_wr_en;
  logic [7:0]       mem_wr_data;
  logic [2:0]       alu_op;
  logic             alu_start;
  logic             alu_addrc;
  logic             alu_cin;
  logic             alu_ovin;
  logic [7:0]       alu_a;
  logic [7:0]       alu_b;
  logic [7:0]       alu_result;
  logic             alu_cout;
`ifdef MPSEQ_ABORT_EN
  logic             abort;
  logic             aborted;
`endif

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, cmd_addr_a, cmd_addr_b, cmd_addr_d,
    input  mem_rd_data, alu_result, alu_cout,
`ifdef MPSEQ_ABORT_EN
    input  abort,
    output aborted,
`endif
    output cmd_ready, busy, done, carry_out,
    output mem_addr, mem_wr_en, mem_wr_data,
    output alu_op, alu_start, alu_addrc, alu_cin, alu_ovin, alu_a, alu_b
  );

  modport master (
    output cmd_valid, cmd_op, cmd_len, cmd_addr_a, cmd_addr_b, cmd_addr_d,
    output mem_rd_data, alu_result, alu_cout,
`ifdef MPSEQ_ABORT_EN
    output abort,
    input  aborted,
`endif
    input  cmd_ready, busy, done, carry_out,
    input  mem_addr, mem_wr_en, mem_wr_data,
    input  alu_op, alu_start, alu_addrc, alu_cin, alu_ovin, alu_a, alu_b
  );
endinterface

// File: rtl/mp_alu_sequencer.sv
// mp_alu_sequencer: walks a 1..15-byte operand through an 8-bit shift/add ALU,
// chaining carry / shifted-out bits between bytes and writing each result byte back.
// Per byte: RDA (issue A read) -> RDB (latch A, issue B read) -> EXEC (ALU) -> WR.
// Optional feature: define MPSEQ_ABORT_EN to add the abort input and aborted pulse.
module mp_alu_sequencer #(
  parameter int AW    = 8,
  parameter int LEN_W = 4
) (
  input logic               CLK,
  input logic               reset,
  mp_alu_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RDA  = 3'd1,
    ST_RDB  = 3'd2,
    ST_EXEC = 3'd3,
    ST_WR   = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  localparam logic [1:0]       OP_ADD   = 2'b00;
  localparam logic [1:0]       OP_SHL   = 2'b01;
  localparam logic [1:0]       OP_SHR   = 2'b10;
  localparam logic [1:0]       OP_SRA   = 2'b11;
  localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
  localparam logic [AW-1:0]    ADDR_ZERO = {AW{1'b0}};

  state_t           state_r;
  logic [1:0]       op_r;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] cnt_r;
  logic [AW-1:0]    base_a_r;
  logic [AW-1:0]    base_b_r;
  logic [AW-1:0]    base_d_r;
  logic [7:0]       a_reg_r;
  logic [7:0]       res_r;
  logic             carry_r;
  logic             cmd_ready_r;
  logic             busy_r;
  logic             done_r;
  logic             carry_out_r;
  logic             mem_wr_en_r;
  logic [AW-1:0]    mem_addr_r;

  logic [AW-1:0]    idx_s;
  logic [AW-1:0]    idx_next_s;
  logic [AW-1:0]    idx_start_s;
  logic             first_s;
  logic             last_s;
  logic             carry_next_s;
  logic             abort_s;

  // Byte offset for the cnt-th processed byte: right shifts walk MSB first.
  function automatic logic [AW-1:0] byte_offset(input logic [1:0]       op,
                                                input logic [LEN_W-1:0] len,
                                                input logic [LEN_W-1:0] cnt);
    logic [LEN_W-1:0] idx;
    if (op[1]) begin
      idx = len - cnt - LEN_ONE;
    end else begin
      idx = cnt;
    end
    return AW'(idx);
  endfunction

  assign idx_s       = byte_offset(op_r, len_r, cnt_r);
  assign idx_next_s  = byte_offset(op_r, len_r, cnt_r + LEN_ONE);
  assign idx_start_s = byte_offset(bus.cmd_op, bus.cmd_len, LEN_ZERO);
  assign first_s     = (cnt_r == LEN_ZERO);
  assign last_s      = (cnt_r == (len_r - LEN_ONE));

  // Carry into the next byte: ALU carry for ADD, the bit shifted out of a_reg for shifts.
  always_comb begin
    carry_next_s = 1'b0;
    case (op_r)
      OP_ADD:  carry_next_s = bus.alu_cout;
      OP_SHL:  carry_next_s = a_reg_r[7];
      OP_SHR:  carry_next_s = a_reg_r[0];
      OP_SRA:  carry_next_s = a_reg_r[0];
      default: carry_next_s = 1'b0;
    endcase
  end

  // ALU drive: combinational in EXEC because operand B arrives from memory that cycle.
  always_comb begin
    bus.alu_op    = 3'b000;
    bus.alu_start = 1'b0;
    bus.alu_addrc = 1'b0;
    bus.alu_cin   = 1'b0;
    bus.alu_ovin  = 1'b0;
    bus.alu_a     = 8'h00;
    bus.alu_b     = 8'h00;
    if (state_r == ST_EXEC) begin
      bus.alu_a = a_reg_r;
      case (op_r)
        OP_ADD: begin
          bus.alu_op = 3'b000;
          bus.alu_b  = bus.mem_rd_data;
          if (first_s) begin
            bus.alu_start = 1'b1;
          end else begin
            bus.alu_addrc = 1'b1;
            bus.alu_cin   = carry_r;
          end
        end
        OP_SHL: begin
          bus.alu_b = 8'h01;
          if (first_s) begin
            bus.alu_op = 3'b010;
          end else begin
            bus.alu_op   = 3'b011;
            bus.alu_ovin = carry_r;
          end
        end
        OP_SHR, OP_SRA: begin
          bus.alu_b = 8'h01;
          if (first_s) begin
            bus.alu_op = (op_r == OP_SHR) ? 3'b110 : 3'b100;
          end else begin
            bus.alu_op   = 3'b101;
            bus.alu_ovin = carry_r;
          end
        end
        default: bus.alu_op = 3'b000;
      endcase
    end else begin
      bus.alu_op = 3'b000;
    end
  end

  // Sequencer FSM with registered memory/handshake outputs.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      op_r        <= 2'b00;
      len_r       <= LEN_ZERO;
      cnt_r       <= LEN_ZERO;
      base_a_r    <= ADDR_ZERO;
      base_b_r    <= ADDR_ZERO;
      base_d_r    <= ADDR_ZERO;
      a_reg_r     <= 8'h00;
      res_r       <= 8'h00;
      carry_r     <= 1'b0;
      cmd_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      carry_out_r <= 1'b0;
      mem_wr_en_r <= 1'b0;
      mem_addr_r  <= ADDR_ZERO;
    end else if (abort_s) begin
      // abandon the command; carry_out keeps the last completed result
      state_r     <= ST_IDLE;
      cmd_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      mem_wr_en_r <= 1'b0;
      mem_addr_r  <= ADDR_ZERO;
      res_r       <= 8'h00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            op_r        <= bus.cmd_op;
            len_r       <= bus.cmd_len;
            base_a_r    <= bus.cmd_addr_a;
            base_b_r    <= bus.cmd_addr_b;
            base_d_r    <= bus.cmd_addr_d;
            cnt_r       <= LEN_ZERO;
            carry_r     <= 1'b0;
            cmd_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            if (bus.cmd_len == LEN_ZERO) begin
              state_r     <= ST_DONE;
              done_r      <= 1'b1;
              carry_out_r <= 1'b0;
            end else begin
              state_r    <= ST_RDA;
              mem_addr_r <= bus.cmd_addr_a + idx_start_s;
            end
          end
        end
        ST_RDA: begin
          state_r    <= ST_RDB;
          mem_addr_r <= base_b_r + idx_s;
        end
        ST_RDB: begin
          state_r    <= ST_EXEC;
          a_reg_r    <= bus.mem_rd_data;
          mem_addr_r <= ADDR_ZERO;
        end
        ST_EXEC: begin
          state_r     <= ST_WR;
          res_r       <= bus.alu_result;
          carry_r     <= carry_next_s;
          mem_wr_en_r <= 1'b1;
          mem_addr_r  <= base_d_r + idx_s;
        end
        ST_WR: begin
          mem_wr_en_r <= 1'b0;
          res_r       <= 8'h00;
          if (last_s) begin
            state_r     <= ST_DONE;
            done_r      <= 1'b1;
            carry_out_r <= carry_r;
            mem_addr_r  <= ADDR_ZERO;
          end else begin
            state_r    <= ST_RDA;
            cnt_r      <= cnt_r + LEN_ONE;
            mem_addr_r <= base_a_r + idx_next_s;
          end
        end
        ST_DONE: begin
          state_r     <= ST_IDLE;
          done_r      <= 1'b0;
          busy_r      <= 1'b0;
          cmd_ready_r <= 1'b1;
        end
        default: begin
          state_r     <= ST_IDLE;
          done_r      <= 1'b0;
          busy_r      <= 1'b0;
          cmd_ready_r <= 1'b1;
          mem_wr_en_r <= 1'b0;
          mem_addr_r  <= ADDR_ZERO;
        end
      endcase
    end
  end

  assign bus.cmd_ready   = cmd_ready_r;
  assign bus.busy        = busy_r;
  assign bus.carry_out   = carry_out_r;
  assign bus.mem_addr    = mem_addr_r;
  assign bus.mem_wr_data = res_r;

`ifdef MPSEQ_ABORT_EN
  logic aborted_r;

  assign abort_s = bus.abort && (state_r != ST_IDLE);

  // One-cycle pulse marking an abandoned command.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      aborted_r <= 1'b0;
    end else begin
      aborted_r <= abort_s;
    end
  end

  // An abort in WR or DONE must suppress the write / completion already on the wires.
  assign bus.aborted   = aborted_r;
  assign bus.mem_wr_en = mem_wr_en_r & ~abort_s;
  assign bus.done      = done_r & ~abort_s;
`else
  assign abort_s       = 1'b0;
  assign bus.mem_wr_en = mem_wr_en_r;
  assign bus.done      = done_r;
`endif

endmodule

// File: tb/tb_mp_alu_sequencer.sv
// tb_mp_alu_sequencer: table-driven check of the multi-byte sequencer with a
// behavioural data memory and 8-bit shift/add ALU, plus reset/abort sequences.
module tb_mp_alu_sequencer;

  typedef struct packed {
    logic [1:0]  op;
    logic [3:0]  len;
    logic [7:0]  a_base;
    logic [7:0]  b_base;
    logic [7:0]  d_base;
    logic [31:0] a_dat;    // byte k at [8k+:8]
    logic [31:0] b_dat;
    logic [31:0] exp_d;
    logic        exp_c;
    logic [7:0]  exp_lat;
    logic [7:0]  exp_ra0;  // A-read address of first processed byte
    logic [7:0]  exp_ra1;  // A-read address of second processed byte
  } vec_t;

  localparam int NVEC = 8;

  logic clk;
  logic rst;
  logic [7:0] mem [256];
  logic       pre_we;
  logic [7:0] pre_addr;
  logic [7:0] pre_data;
  logic       alu_cin_eff;
  logic [8:0] alu_sum;
  int n_pass;
  int n_total;
  vec_t vecs [NVEC];

  mp_alu_sequencer_if #(.AW(8), .LEN_W(4)) bus ();

  mp_alu_sequencer #(.AW(8), .LEN_W(4)) dut (
    .CLK   (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // synchronous-read data memory with a bench-side preload port
  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end else if (bus.mem_wr_en) begin
      mem[bus.mem_addr] <= bus.mem_wr_data;
    end
    bus.mem_rd_data <= mem[bus.mem_addr];
  end

  // behavioural 8-bit shift/add ALU
  always_comb begin
    alu_cin_eff    = bus.alu_start ? 1'b0 : (bus.alu_addrc & bus.alu_cin);
    alu_sum        = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {8'd0, alu_cin_eff};
    bus.alu_result = 8'h00;
    bus.alu_cout   = 1'b0;
    case (bus.alu_op)
      3'b000: begin bus.alu_result = alu_sum[7:0]; bus.alu_cout = alu_sum[8]; end
      3'b010: bus.alu_result = {bus.alu_a[6:0], 1'b0};
      3'b011: bus.alu_result = {bus.alu_a[6:0], bus.alu_ovin};
      3'b110: bus.alu_result = {1'b0, bus.alu_a[7:1]};
      3'b100: bus.alu_result = {bus.alu_a[7], bus.alu_a[7:1]};
      3'b101: bus.alu_result = {bus.alu_ovin, bus.alu_a[7:1]};
      default: bus.alu_result = 8'h00;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic poke(input logic [7:0] addr, input logic [7:0] data);
    @(negedge clk);
    pre_we   = 1'b1;
    pre_addr = addr;
    pre_data = data;
    @(negedge clk);
    pre_we   = 1'b0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [3:0] len,
                       input logic [7:0] a, input logic [7:0] b, input logic [7:0] d);
    @(negedge clk);
    bus.cmd_valid  = 1'b1;
    bus.cmd_op     = op;
    bus.cmd_len    = len;
    bus.cmd_addr_a = a;
    bus.cmd_addr_b = b;
    bus.cmd_addr_d = d;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    int   lat;
    int   wr_cnt;
    logic got;
    logic [7:0] ra0;
    logic [7:0] ra1;
    logic [7:0] bsy1;
    v = vecs[i];
    for (int k = 0; k < int'(v.len); k++) poke(v.d_base + 8'(k), 8'hEE);
    for (int k = 0; k < int'(v.len); k++) poke(v.a_base + 8'(k), v.a_dat[8*k +: 8]);
    if (v.op == 2'b00) begin
      for (int k = 0; k < int'(v.len); k++) poke(v.b_base + 8'(k), v.b_dat[8*k +: 8]);
    end
    issue(v.op, v.len, v.a_base, v.b_base, v.d_base);
    got = 1'b0; lat = 0; wr_cnt = 0; ra0 = 8'h00; ra1 = 8'h00; bsy1 = 8'h00;
    for (int c = 1; c <= 100 && !got; c++) begin
      @(negedge clk);
      if (c == 1) begin ra0 = bus.mem_addr; bsy1 = {7'd0, bus.busy}; end
      if (c == 5) ra1 = bus.mem_addr;
      if (bus.mem_wr_en) wr_cnt++;
      if (bus.done) begin got = 1'b1; lat = c; end
    end
    check($sformatf("v%0d done_seen", i), {31'd0, got}, 32'd1);
    check($sformatf("v%0d latency", i), lat, {24'd0, v.exp_lat});
    check($sformatf("v%0d carry_out", i), {31'd0, bus.carry_out}, {31'd0, v.exp_c});
    check($sformatf("v%0d write_count", i), wr_cnt, {28'd0, v.len});
    check($sformatf("v%0d busy", i), {24'd0, bsy1}, 32'd1);
    if (v.len >= 4'd2) begin
      check($sformatf("v%0d rd_addr0", i), {24'd0, ra0}, {24'd0, v.exp_ra0});
      check($sformatf("v%0d rd_addr1", i), {24'd0, ra1}, {24'd0, v.exp_ra1});
    end
    for (int k = 0; k < int'(v.len); k++) begin
      check($sformatf("v%0d d[%0d]", i, k), {24'd0, mem[v.d_base + 8'(k)]}, {24'd0, v.exp_d[8*k +: 8]});
    end
    @(negedge clk);
    check($sformatf("v%0d ready_after", i), {30'd0, bus.cmd_ready, bus.busy}, 32'd2);
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; pre_we = 1'b0; pre_addr = 8'h00; pre_data = 8'h00;
    n_pass = 0; n_total = 0;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_len = 4'd0;
    bus.cmd_addr_a = 8'h00; bus.cmd_addr_b = 8'h00; bus.cmd_addr_d = 8'h00;
`ifdef MPSEQ_ABORT_EN
    bus.abort = 1'b0;
`endif
    for (int k = 0; k < 256; k++) mem[k] = 8'h00;

    //          op     len   A      B      D      A bytes        B bytes        expected D     c     lat   ra0    ra1
    vecs[0] = '{2'b00, 4'd2, 8'h10, 8'h20, 8'h30, 32'h0000_01FF, 32'h0000_0001, 32'h0000_0200, 1'b0, 8'd9,  8'h10, 8'h11};
    vecs[1] = '{2'b00, 4'd1, 8'h40, 8'h41, 8'h42, 32'h0000_0080, 32'h0000_0080, 32'h0000_0000, 1'b1, 8'd5,  8'h40, 8'h00};
    vecs[2] = '{2'b01, 4'd3, 8'h50, 8'h00, 8'h60, 32'h0080_8080, 32'h0000_0000, 32'h0001_0100, 1'b1, 8'd13, 8'h50, 8'h51};
    vecs[3] = '{2'b11, 4'd2, 8'h70, 8'h00, 8'h80, 32'h0000_8001, 32'h0000_0000, 32'h0000_C000, 1'b1, 8'd9,  8'h71, 8'h70};
    vecs[4] = '{2'b10, 4'd2, 8'h70, 8'h00, 8'h84, 32'h0000_8001, 32'h0000_0000, 32'h0000_4000, 1'b1, 8'd9,  8'h71, 8'h70};
    vecs[5] = '{2'b00, 4'd0, 8'h90, 8'h91, 8'h92, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 8'd1,  8'h00, 8'h00};
    vecs[6] = '{2'b00, 4'd2, 8'hFF, 8'h94, 8'hA0, 32'h0000_3412, 32'h0000_0101, 32'h0000_3513, 1'b0, 8'd9,  8'hFF, 8'h00};
    vecs[7] = '{2'b01, 4'd2, 8'hC0, 8'h00, 8'hC0, 32'h0000_0181, 32'h0000_0000, 32'h0000_0302, 1'b0, 8'd9,  8'hC0, 8'hC1};

    // reset state
    #12;
    check("rst cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    check("rst busy", {31'd0, bus.busy}, 32'd0);
    check("rst done", {31'd0, bus.done}, 32'd0);
    check("rst mem_wr_en", {31'd0, bus.mem_wr_en}, 32'd0);
    check("rst carry_out", {31'd0, bus.carry_out}, 32'd0);
    check("rst mem_addr", {24'd0, bus.mem_addr}, 32'd0);
    check("rst alu_op", {29'd0, bus.alu_op}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) run_vec(i);

    // reset asserted while the write strobe is up
    begin
      logic seen;
      seen = 1'b0;
      poke(8'hB2, 8'h55);
      poke(8'hB0, 8'h05);
      poke(8'hB1, 8'h06);
      issue(2'b00, 4'd1, 8'hB0, 8'hB1, 8'hB2);
      for (int c = 0; c < 20 && !seen; c++) begin
        @(negedge clk);
        if (bus.mem_wr_en) seen = 1'b1;
      end
      check("rstwr wr_seen", {31'd0, seen}, 32'd1);
      #1 rst = 1'b1;
      #1;
      check("rstwr mem_wr_en", {31'd0, bus.mem_wr_en}, 32'd0);
      check("rstwr busy", {31'd0, bus.busy}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rstwr cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
      check("rstwr no_write", {24'd0, mem[8'hB2]}, 32'h55);
    end

`ifdef MPSEQ_ABORT_EN
    // abort while in RDB: no write, no done, aborted pulse, carry_out kept
    begin
      logic bad;
      bad = 1'b0;
      poke(8'hCA, 8'h77);
      poke(8'hC8, 8'h05);
      poke(8'hC9, 8'h06);
      issue(2'b00, 4'd1, 8'hC8, 8'hC9, 8'hCA);
      @(negedge clk);      // RDA
      @(negedge clk);      // RDB
      bus.abort = 1'b1;
      @(posedge clk);
      #1 bus.abort = 1'b0;
      check("abort aborted", {31'd0, bus.aborted}, 32'd1);
      check("abort cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
      check("abort busy", {31'd0, bus.busy}, 32'd0);
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (bus.done || bus.mem_wr_en || bus.aborted) bad = 1'b1;
      end
      check("abort quiet_after", {31'd0, bad}, 32'd0);
      check("abort no_write", {24'd0, mem[8'hCA]}, 32'h77);
      check("abort carry_out", {31'd0, bus.carry_out}, 32'd0);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
